exec_unit: RTL and testbench

- Parametrised successor to the single-cycle ALU/branch-compare pair: one execution unit handling RV32I/RV64I integer ops, branch conditions and the M extension (MUL/MULH*/DIV*/REM*).
- Sits between decode and writeback in the multi-cycle core.
- Valid/ready handshakes on both sides, so the core stalls on iterative multiply/divide instead of assuming a fixed 6-step sequence.
- A flush input kills in-flight work on trap or redirect.

---
 rtl/exec_pkg.sv | 48 ++++
 rtl/muldiv_iter.sv | 85 ++++++++
 rtl/exec_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_exec_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module : exec_pkg
// Brief  : Shared encodings for the execution unit (op classes, funct3, FSM).
// Rev    : 1.0  initial release
// ============================================================================
package exec_pkg;

    localparam logic [1:0] OPC_ALU    = 2'b00;
    localparam logic [1:0] OPC_BRANCH = 2'b01;
    localparam logic [1:0] OPC_MULDIV = 2'b10;
    localparam logic [1:0] OPC_RSVD   = 2'b11;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module : muldiv_iter
// Brief  : One-bit-per-cycle unsigned shift-add multiply / restoring divide.
// Rev    : 1.0  initial release
// ============================================================================
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int              c_cw   = $clog2(XLEN);
    localparam logic [c_cw-1:0] c_last = c_cw'(XLEN - 1);

    logic            run_q;
    logic            div_q;
    logic [c_cw-1:0] cnt_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] b_q;

    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_sub;
    logic            w_ge;

    // hi/lo double as product {hi,lo} for multiply and {remainder,quotient} for divide
    always_comb begin
        w_mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        w_shift   = {hi_q, lo_q[XLEN-1]};
        w_ge      = (w_shift >= {1'b0, b_q});
        w_sub     = w_shift[XLEN-1:0] - b_q;
    end

    assign done_o = run_q && (cnt_q == c_last);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q <= 1'b0;
            div_q <= 1'b0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
        end else if (flush_i) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            div_q <= is_div_i;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= a_i;
            b_q   <= b_i;
        end else if (run_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                run_q <= 1'b0;
            end
            if (div_q) begin
                hi_q <= w_ge ? w_sub : w_shift[XLEN-1:0];
                lo_q <= {lo_q[XLEN-2:0], w_ge};
            end else begin
                hi_q <= w_mul_sum[XLEN:1];
                lo_q <= {w_mul_sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// Module : exec_unit
// Brief  : RV32I/RV64I ALU, branch compare and iterative M-extension unit.
// Rev    : 1.0  initial release
// ============================================================================
module exec_unit
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op_class,
    input  logic [2:0]      funct3,
    input  logic            alt,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            taken,
    output logic            busy
);

    localparam logic [XLEN-1:0] c_min = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            taken_q, taken_d;
    logic [2:0]      md_op_q, md_op_d;
    logic            md_neg_q, md_neg_d;
    logic            md_dz_q, md_dz_d;
    logic            md_ovf_q, md_ovf_d;
    logic [XLEN-1:0] md_x_q, md_x_d;

    logic            w_accept;
    logic            w_md_start;
    logic            w_md_done;
    logic [XLEN-1:0] w_md_hi, w_md_lo;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_alu;
    logic            w_eq, w_lt, w_ltu, w_br;
    logic            w_xs, w_ys, w_xneg, w_yneg, w_neg, w_dz, w_ovf;
    logic [XLEN-1:0] w_xmag, w_ymag;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0] w_quo, w_rem, w_fix;

    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign taken     = taken_q;
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);

    always_comb begin
        w_shamt = y[SHW-1:0];
        w_eq    = (x == y);
        w_lt    = ($signed(x) < $signed(y));
        w_ltu   = (x < y);
        case (funct3)
            F3_ADD:  w_alu = alt ? (x - y) : (x + y);
            F3_SLL:  w_alu = x << w_shamt;
            F3_SLT:  w_alu = {{(XLEN-1){1'b0}}, w_lt};
            F3_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_ltu};
            F3_XOR:  w_alu = x ^ y;
            F3_SR:   w_alu = alt ? $unsigned($signed(x) >>> w_shamt) : (x >> w_shamt);
            F3_OR:   w_alu = x | y;
            default: w_alu = x & y;
        endcase
        case (funct3)
            F3_BEQ:  w_br = w_eq;
            F3_BNE:  w_br = !w_eq;
            F3_BLT:  w_br = w_lt;
            F3_BGE:  w_br = !w_lt;
            F3_BLTU: w_br = w_ltu;
            F3_BGEU: w_br = !w_ltu;
            default: w_br = 1'b0;
        endcase
    end

    // Operand magnitudes and result sign; the iterator itself is purely unsigned
    always_comb begin
        w_xs   = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                 (funct3 == F3_DIV)  || (funct3 == F3_REM);
        w_ys   = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        w_xneg = w_xs && x[XLEN-1];
        w_yneg = w_ys && y[XLEN-1];
        w_xmag = w_xneg ? (~x + 1'b1) : x;
        w_ymag = w_yneg ? (~y + 1'b1) : y;
        if (funct3[2]) begin
            w_neg = funct3[1] ? w_xneg : (w_xneg ^ w_yneg);
        end else begin
            w_neg = w_xneg ^ w_yneg;
        end
        w_dz  = funct3[2] && (y == '0);
        w_ovf = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (x == c_min) && (y == '1);
    end

    always_comb begin
        w_prod   = {w_md_hi, w_md_lo};
        w_prod_s = md_neg_q ? (~w_prod + 1'b1) : w_prod;
        w_quo    = md_neg_q ? (~w_md_lo + 1'b1) : w_md_lo;
        w_rem    = md_neg_q ? (~w_md_hi + 1'b1) : w_md_hi;
        case (md_op_q)
            F3_MUL:             w_fix = w_prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU,
            F3_MULHU:           w_fix = w_prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:    w_fix = md_dz_q ? '1 : (md_ovf_q ? md_x_q : w_quo);
            default:            w_fix = md_dz_q ? md_x_q : (md_ovf_q ? '0 : w_rem);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        taken_d     = taken_q;
        md_op_d     = md_op_q;
        md_neg_d    = md_neg_q;
        md_dz_d     = md_dz_q;
        md_ovf_d    = md_ovf_q;
        md_x_d      = md_x_q;
        w_md_start  = 1'b0;
        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                    end
                    if (w_accept) begin
                        case (op_class)
                            OPC_ALU: begin
                                out_valid_d = 1'b1;
                                result_d    = w_alu;
                                taken_d     = 1'b0;
                            end
                            OPC_BRANCH: begin
                                out_valid_d = 1'b1;
                                result_d    = '0;
                                taken_d     = w_br;
                            end
                            OPC_MULDIV: begin
                                md_op_d  = funct3;
                                md_neg_d = w_neg;
                                md_dz_d  = w_dz;
                                md_ovf_d = w_ovf;
                                md_x_d   = x;
                                if (w_dz || w_ovf) begin
                                    state_d = S_FIX;
                                end else begin
                                    w_md_start = 1'b1;
                                    state_d    = funct3[2] ? S_DIV : S_MUL;
                                end
                            end
                            default: begin
                                out_valid_d = 1'b1;
                                result_d    = '0;
                                taken_d     = 1'b0;
                            end
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (w_md_done) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    result_d = w_fix;
                    taken_d  = 1'b0;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            taken_q     <= 1'b0;
            md_op_q     <= '0;
            md_neg_q    <= 1'b0;
            md_dz_q     <= 1'b0;
            md_ovf_q    <= 1'b0;
            md_x_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            taken_q     <= taken_d;
            md_op_q     <= md_op_d;
            md_neg_q    <= md_neg_d;
            md_dz_q     <= md_dz_d;
            md_ovf_q    <= md_ovf_d;
            md_x_q      <= md_x_d;
        end
    end

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk      (clk),
        .resetn   (resetn),
        .flush_i  (flush),
        .start_i  (w_md_start),
        .is_div_i (funct3[2]),
        .a_i      (w_xmag),
        .b_i      (w_ymag),
        .done_o   (w_md_done),
        .hi_o     (w_md_hi),
        .lo_o     (w_md_lo)
    );

endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_exec_unit
// Brief  : Scoreboard bench for exec_unit at XLEN=32 and XLEN=64.
// Rev    : 1.0  initial release
// ============================================================================
module tb_exec_unit;
    import exec_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid, in_ready, alt, flush, out_valid, out_ready, taken, busy;
    logic [1:0]  op_class;
    logic [2:0]  funct3;
    logic [31:0] x, y, result;

    logic        v64, r64, ov64, tk64, bz64;
    logic [2:0]  f64;
    logic [63:0] x64, y64, res64;

    exec_unit #(.XLEN(32)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .op_class(op_class), .funct3(funct3), .alt(alt), .x(x), .y(y),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .taken(taken), .busy(busy)
    );

    exec_unit #(.XLEN(64)) dut64 (
        .clk(clk), .resetn(resetn), .in_valid(v64), .in_ready(r64),
        .op_class(OPC_MULDIV), .funct3(f64), .alt(1'b0), .x(x64), .y(y64),
        .flush(1'b0), .out_valid(ov64), .out_ready(1'b1),
        .result(res64), .taken(tk64), .busy(bz64)
    );

    typedef struct {
        logic [63:0] res;
        logic        tk;
        string       tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (q32.size() == 0) begin
                chk("unexpected_out32", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk({e.tag, "_result"}, 64'(result), e.res);
                chk({e.tag, "_taken"}, 64'(taken), 64'(e.tk));
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && ov64) begin
            if (q64.size() == 0) begin
                chk("unexpected_out64", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q64.pop_front();
                chk({e.tag, "_result"}, res64, e.res);
                chk({e.tag, "_taken"}, 64'(tk64), 64'(e.tk));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic issue(input logic [1:0] c, input logic [2:0] f, input logic a,
                         input logic [31:0] xa, input logic [31:0] ya,
                         input logic [31:0] er, input logic et, input bit push,
                         input string tag, output int waits);
        exp_t e;
        op_class = c; funct3 = f; alt = a; x = xa; y = ya; in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
        if (push) begin
            e.res = 64'(er); e.tk = et; e.tag = tag;
            q32.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_md(input logic [2:0] f, input logic [31:0] xa, input logic [31:0] ya,
                          input logic [31:0] er, input string tag,
                          input int elat, input int ebusy);
        int w, t0, lat, bc, rc;
        issue(OPC_MULDIV, f, 1'b0, xa, ya, er, 1'b0, 1'b1, tag, w);
        t0 = cyc; lat = -1; bc = 0; rc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - t0;
                break;
            end
            if (busy) bc++;
            if (in_ready) rc++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(ebusy));
        chk({tag, "_in_ready_cycles"}, 64'(rc), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run64(input logic [2:0] f, input logic [63:0] xa, input logic [63:0] ya,
                         input logic [63:0] er, input string tag,
                         input int elat, input int ebusy);
        exp_t e;
        int k, t0, lat, bc;
        f64 = f; x64 = xa; y64 = ya; v64 = 1'b1; k = 0;
        @(negedge clk);
        while (!r64 && k < 100) begin
            k++;
            @(negedge clk);
        end
        if (!r64) chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
        e.res = er; e.tk = 1'b0; e.tag = tag;
        q64.push_back(e);
        @(posedge clk);
        #1;
        v64 = 1'b0; t0 = cyc; lat = -1; bc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ov64) begin
                lat = cyc - t0;
                break;
            end
            if (bz64) bc++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(ebusy));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, c0, cnt;
        resetn = 1'b0; in_valid = 1'b0; op_class = 2'b00; funct3 = 3'b000; alt = 1'b0;
        x = '0; y = '0; flush = 1'b0; out_ready = 1'b1;
        v64 = 1'b0; f64 = 3'b000; x64 = '0; y64 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_taken", 64'(taken), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // ALU
        issue(OPC_ALU, F3_ADD, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1, "add", w);
        @(negedge clk);
        chk("add_latency1", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        issue(OPC_ALU, F3_ADD, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, "sub", w);
        issue(OPC_ALU, F3_SR, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b1, "sra", w);
        issue(OPC_ALU, F3_SR, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b1, "srl", w);
        issue(OPC_ALU, F3_SLL, 1'b0, 32'd1, 32'd35, 32'd8, 1'b0, 1'b1, "sll_shamt", w);
        issue(OPC_ALU, F3_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b1, "slt", w);
        issue(OPC_ALU, F3_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, "sltu", w);
        issue(OPC_ALU, F3_XOR, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1'b1, "xor", w);

        // Branches, issued back to back
        issue(OPC_BRANCH, F3_BLT, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1, "blt", w);
        c0 = cyc;
        issue(OPC_BRANCH, F3_BLTU, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, "bltu", w);
        issue(OPC_BRANCH, F3_BEQ, 1'b0, 32'd3, 32'd3, 32'd0, 1'b1, 1'b1, "beq", w);
        issue(OPC_BRANCH, F3_BGE, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, "bge", w);
        chk("b2b_cycles", 64'(cyc - c0), 64'd3);
        issue(OPC_BRANCH, F3_BNE, 1'b0, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, "bne", w);
        issue(OPC_BRANCH, F3_BGEU, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, "bgeu", w);
        issue(OPC_BRANCH, 3'b010, 1'b0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, "br_undef", w);
        issue(OPC_ALU, F3_ADD, 1'b0, 32'd5, 32'd6, 32'd11, 1'b0, 1'b1, "add2", w);
        issue(OPC_RSVD, F3_ADD, 1'b0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, "rsvd", w);

        // Multiply / divide
        run_md(F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh", 34, 32);
        run_md(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul", 34, 32);
        run_md(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu", 34, 32);
        run_md(F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "mulhsu", 34, 32);
        run_md(F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div", 34, 32);
        run_md(F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem", 34, 32);
        run_md(F3_DIVU, 32'd100, 32'd7, 32'd14, "divu", 34, 32);
        run_md(F3_REMU, 32'd100, 32'd7, 32'd2, "remu", 34, 32);
        run_md(F3_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, "divu_by0", 2, 0);
        run_md(F3_REM, 32'd7, 32'd0, 32'd7, "rem_by0", 2, 0);
        run_md(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf", 2, 0);
        run_md(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf", 2, 0);

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        issue(OPC_ALU, F3_ADD, 1'b0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1, "bp", w);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_result", 64'(result), 64'd3);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(OPC_ALU, F3_ADD, 1'b1, 32'd10, 32'd3, 32'd7, 1'b0, 1'b1, "bp_next", w);
        chk("bp_same_cycle_accept", 64'(w), 64'd0);

        // Flush in the middle of a divide
        issue(OPC_MULDIV, F3_DIVU, 1'b0, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, "divu_fl", w);
        repeat (9) @(posedge clk);
        #1;
        chk("fl_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_busy_after", 64'(busy), 64'd0);
        chk("fl_in_ready_after", 64'(in_ready), 64'd1);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("fl_no_out_valid", 64'(cnt), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        issue(OPC_ALU, F3_ADD, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, "fl_xfer", w);
        flush = 1'b0;
        @(negedge clk);
        chk("fl_xfer_dropped", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a multiply
        issue(OPC_MULDIV, F3_MUL, 1'b0, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, "mul_rst", w);
        repeat (5) @(posedge clk);
        #2;
        chk("rm_busy_before", 64'(busy), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rm_busy", 64'(busy), 64'd0);
        chk("rm_result", 64'(result), 64'd0);
        chk("rm_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        issue(OPC_ALU, F3_ADD, 1'b0, 32'd20, 32'd22, 32'd42, 1'b0, 1'b1, "post_rst", w);

        // XLEN = 64
        run64(F3_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'h4000_0000_0000_0000, "mulh64", 66, 64);
        run64(F3_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, "mul64", 66, 64);
        run64(F3_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, "mulhu64", 66, 64);
        run64(F3_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div64", 66, 64);

        for (int k = 0; k < 50; k++) begin
            if (q32.size() == 0 && q64.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drained", 64'(q32.size() + q64.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
